// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 timing, timing record and colour type.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33
  };

  typedef logic [3:0] color_t;

  // Stage-0 control bits carried through the drawer-alignment pipeline.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } sync_bundle_t;

  function automatic int unsigned line_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async active-low reset; DEPTH=0 is a wire.
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift din through DEPTH registers; reset clears every stage to inactive.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA output stage: timing counters, scaled drawer coordinates, sync/enable
// alignment to the drawer latency, and registered DAC outputs.
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE       = DEF_H_ACTIVE,
  parameter int unsigned H_FP           = DEF_H_FP,
  parameter int unsigned H_SYNC         = DEF_H_SYNC,
  parameter int unsigned H_BP           = DEF_H_BP,
  parameter int unsigned V_ACTIVE       = DEF_V_ACTIVE,
  parameter int unsigned V_FP           = DEF_V_FP,
  parameter int unsigned V_SYNC         = DEF_V_SYNC,
  parameter int unsigned V_BP           = DEF_V_BP,
  parameter bit          H_POL          = 1'b0,
  parameter bit          V_POL          = 1'b0,
  parameter int unsigned SCALE_SHIFT    = 0,
  parameter int unsigned DRAW_LATENCY   = 1,
  parameter int unsigned COLOR_BITS     = 4,
  parameter int unsigned FRAME_CNT_BITS = 16
) (
  input  logic                      vga_clock,
  input  logic                      reset,
  input  logic                      force_blank,
  input  logic [COLOR_BITS-1:0]     red,
  input  logic [COLOR_BITS-1:0]     green,
  input  logic [COLOR_BITS-1:0]     blue,
  output logic [15:0]               column,
  output logic [15:0]               row,
  output logic                      pixel_active,
  output logic                      line_start,
  output logic                      frame_start,
  output logic [FRAME_CNT_BITS-1:0] frame_count,
  output logic                      hsync,
  output logic                      vsync,
  output logic [COLOR_BITS-1:0]     vga_red,
  output logic [COLOR_BITS-1:0]     vga_green,
  output logic [COLOR_BITS-1:0]     vga_blue
);

  localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
  localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEGIN = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEGIN = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (SCALE_SHIFT > 3) begin : g_bad_shift
      $fatal(1, "vga_timing_pipe: SCALE_SHIFT must be 0..3");
    end
    if ((H_ACTIVE % (1 << SCALE_SHIFT)) != 0 || (V_ACTIVE % (1 << SCALE_SHIFT)) != 0) begin : g_bad_scale
      $fatal(1, "vga_timing_pipe: active area not divisible by 2**SCALE_SHIFT");
    end
    if (DRAW_LATENCY > 15) begin : g_bad_latency
      $fatal(1, "vga_timing_pipe: DRAW_LATENCY must be <= 15");
    end
    if (H_TOTAL >= 65536 || V_TOTAL >= 65536) begin : g_bad_total
      $fatal(1, "vga_timing_pipe: H_TOTAL and V_TOTAL must be < 65536");
    end
  endgenerate

  logic [15:0]  h_count;
  logic [15:0]  v_count;
  logic         h_wrap;
  logic         v_wrap;
  logic         h_vis;
  logic         v_vis;
  sync_bundle_t stage0;
  sync_bundle_t aligned;
  logic         show_color;

  // Stage-0 decode of the counters: coordinates, strobes and raw sync levels.
  always_comb begin
    h_wrap       = (h_count == H_LAST);
    v_wrap       = (v_count == V_LAST);
    h_vis        = (h_count < H_VIS);
    v_vis        = (v_count < V_VIS);
    pixel_active = h_vis && v_vis;
    column       = pixel_active ? (h_count >> SCALE_SHIFT) : '0;
    row          = pixel_active ? (v_count >> SCALE_SHIFT) : '0;
    line_start   = (h_count == '0) && v_vis;
    frame_start  = (h_count == '0) && (v_count == '0);
    stage0.active = pixel_active;
    stage0.hs     = (h_count >= HS_BEGIN) && (h_count < HS_END);
    stage0.vs     = (v_count >= VS_BEGIN) && (v_count < VS_END);
  end

  // Pixel/line counters and completed-frame counter.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      h_count     <= '0;
      v_count     <= '0;
      frame_count <= '0;
    end else if (h_wrap) begin
      h_count <= '0;
      if (v_wrap) begin
        v_count     <= '0;
        frame_count <= frame_count + FRAME_CNT_BITS'(1);
      end else begin
        v_count <= v_count + 16'd1;
      end
    end else begin
      h_count <= h_count + 16'd1;
    end
  end

  vga_delay_line #(
    .WIDTH ($bits(sync_bundle_t)),
    .DEPTH (DRAW_LATENCY)
  ) u_align (
    .clk   (vga_clock),
    .rst_n (reset),
    .din   (stage0),
    .dout  (aligned)
  );

  // force_blank acts on the output register directly, not through the pipeline.
  always_comb begin
    show_color = aligned.active && !force_blank;
  end

  // Output register driving the DAC pins; reset forces inactive syncs and black.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      hsync     <= ~H_POL;
      vsync     <= ~V_POL;
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
    end else begin
      hsync     <= aligned.hs ? H_POL : ~H_POL;
      vsync     <= aligned.vs ? V_POL : ~V_POL;
      vga_red   <= show_color ? red   : '0;
      vga_green <= show_color ? green : '0;
      vga_blue  <= show_color ? blue  : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Self-checking bench for vga_timing_pipe: three configurations against a
// cycle-count based reference model, plus a reset-release vector table and
// an asynchronous mid-line reset.
module tb_vga_timing_pipe;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, hpol, vpol, sh, lat, fbits;
  } cfg_t;

  typedef struct {
    int col, row, act, ls, fs, fc, hs, vs, pact;
  } exp_t;

  typedef struct {
    logic [3:0] r, g, b;
    logic       fb;
  } drive_t;

  typedef struct {
    logic [3:0]  r;
    logic        fb;
    logic [15:0] col;
    logic        act, fs, ls, hs;
    logic [3:0]  vr;
  } vec_t;

  localparam int MAXC = 2400;
  localparam int NV   = 7;
  localparam int RUN1 = 2303;
  localparam int RUN2 = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int passed = 0;
  int total  = 0;

  cfg_t ca, cb, cc;
  vec_t vec [NV];
  drive_t ha [MAXC];
  drive_t hb [MAXC];
  drive_t hc [MAXC];
  logic [15:0] bcol [MAXC];
  drive_t z;

  // DUT A: default 640x480 timing
  logic a_fb; logic [3:0] a_r, a_g, a_b;
  logic [15:0] a_col, a_row, a_fc; logic a_act, a_ls, a_fs, a_hs, a_vs;
  logic [3:0] a_vr, a_vg, a_vb;
  // DUT B: small timing, positive syncs, SCALE_SHIFT=1, DRAW_LATENCY=3
  logic b_fb; logic [3:0] b_r, b_g, b_b;
  logic [15:0] b_col, b_row, b_fc; logic b_act, b_ls, b_fs, b_hs, b_vs;
  logic [3:0] b_vr, b_vg, b_vb;
  // DUT C: tiny timing, SCALE_SHIFT=2, DRAW_LATENCY=0, 3-bit frame counter
  logic c_fb; logic [3:0] c_r, c_g, c_b;
  logic [15:0] c_col, c_row; logic [2:0] c_fc; logic c_act, c_ls, c_fs, c_hs, c_vs;
  logic [3:0] c_vr, c_vg, c_vb;

  vga_timing_pipe #(.DRAW_LATENCY(1), .SCALE_SHIFT(0)) u_a (
    .vga_clock(clk), .reset(rst_n), .force_blank(a_fb),
    .red(a_r), .green(a_g), .blue(a_b),
    .column(a_col), .row(a_row), .pixel_active(a_act), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc), .hsync(a_hs), .vsync(a_vs),
    .vga_red(a_vr), .vga_green(a_vg), .vga_blue(a_vb));

  vga_timing_pipe #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b1), .V_POL(1'b1), .SCALE_SHIFT(1), .DRAW_LATENCY(3),
    .COLOR_BITS(4), .FRAME_CNT_BITS(16)
  ) u_b (
    .vga_clock(clk), .reset(rst_n), .force_blank(b_fb),
    .red(b_r), .green(b_g), .blue(b_b),
    .column(b_col), .row(b_row), .pixel_active(b_act), .line_start(b_ls),
    .frame_start(b_fs), .frame_count(b_fc), .hsync(b_hs), .vsync(b_vs),
    .vga_red(b_vr), .vga_green(b_vg), .vga_blue(b_vb));

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b1), .SCALE_SHIFT(2), .DRAW_LATENCY(0),
    .COLOR_BITS(4), .FRAME_CNT_BITS(3)
  ) u_c (
    .vga_clock(clk), .reset(rst_n), .force_blank(c_fb),
    .red(c_r), .green(c_g), .blue(c_b),
    .column(c_col), .row(c_row), .pixel_active(c_act), .line_start(c_ls),
    .frame_start(c_fs), .frame_count(c_fc), .hsync(c_hs), .vsync(c_vs),
    .vga_red(c_vr), .vga_green(c_vg), .vga_blue(c_vb));

  // Reference: state derived from the cycle count c since reset release
  // (c=0 is the cycle before the first post-release edge).
  function automatic exp_t model(input cfg_t g, input int c);
    exp_t e;
    int ht, vt, h, v, tp, hp, vp;
    ht = g.ha + g.hfp + g.hsw + g.hbp;
    vt = g.va + g.vfp + g.vsw + g.vbp;
    h = c % ht;
    v = (c / ht) % vt;
    e.act = (h < g.ha && v < g.va) ? 1 : 0;
    e.col = e.act ? (h >> g.sh) : 0;
    e.row = e.act ? (v >> g.sh) : 0;
    e.ls  = (h == 0 && v < g.va) ? 1 : 0;
    e.fs  = (h == 0 && v == 0) ? 1 : 0;
    e.fc  = (c / (ht * vt)) % (1 << g.fbits);
    tp = c - g.lat - 1;
    if (tp < 0) begin
      e.pact = 0;
      e.hs = 1 - g.hpol;
      e.vs = 1 - g.vpol;
    end else begin
      hp = tp % ht;
      vp = (tp / ht) % vt;
      e.pact = (hp < g.ha && vp < g.va) ? 1 : 0;
      e.hs = (hp >= g.ha + g.hfp && hp < g.ha + g.hfp + g.hsw) ? g.hpol : 1 - g.hpol;
      e.vs = (vp >= g.va + g.vfp && vp < g.va + g.vfp + g.vsw) ? g.vpol : 1 - g.vpol;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] actual,
                     input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, c, actual, expected);
    else
      passed++;
  endtask

  task automatic check_dut(input string tag, input cfg_t g, input int c,
                           input logic [15:0] col, input logic [15:0] row,
                           input logic act, input logic ls, input logic fs,
                           input logic [15:0] fc, input logic hs, input logic vs,
                           input logic [3:0] vr, input logic [3:0] vg, input logic [3:0] vb,
                           input drive_t prev);
    exp_t e;
    int show;
    e = model(g, c);
    show = (e.pact != 0 && !prev.fb) ? 1 : 0;
    chk({tag, ".column"},       c, 32'(col), e.col);
    chk({tag, ".row"},          c, 32'(row), e.row);
    chk({tag, ".pixel_active"}, c, 32'(act), e.act);
    chk({tag, ".line_start"},   c, 32'(ls),  e.ls);
    chk({tag, ".frame_start"},  c, 32'(fs),  e.fs);
    chk({tag, ".frame_count"},  c, 32'(fc),  e.fc);
    chk({tag, ".hsync"},        c, 32'(hs),  e.hs);
    chk({tag, ".vsync"},        c, 32'(vs),  e.vs);
    chk({tag, ".vga_red"},      c, 32'(vr),  show ? 32'(prev.r) : 0);
    chk({tag, ".vga_green"},    c, 32'(vg),  show ? 32'(prev.g) : 0);
    chk({tag, ".vga_blue"},     c, 32'(vb),  show ? 32'(prev.b) : 0);
  endtask

  task automatic check_all(input string sfx, input int c, input drive_t pa,
                           input drive_t pb, input drive_t pc);
    check_dut({"a", sfx}, ca, c, a_col, a_row, a_act, a_ls, a_fs, a_fc, a_hs, a_vs,
              a_vr, a_vg, a_vb, pa);
    check_dut({"b", sfx}, cb, c, b_col, b_row, b_act, b_ls, b_fs, b_fc, b_hs, b_vs,
              b_vr, b_vg, b_vb, pb);
    check_dut({"c", sfx}, cc, c, c_col, c_row, c_act, c_ls, c_fs, {13'd0, c_fc}, c_hs, c_vs,
              c_vr, c_vg, c_vb, pc);
  endtask

  // Release reset at a falling edge, then check and drive once per cycle.
  task automatic run(input int ncyc, input bit use_table);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (c == 0) check_all("", c, z, z, z);
      else        check_all("", c, ha[c-1], hb[c-1], hc[c-1]);

      if (use_table && c < NV) begin
        chk("tab.column",       c, 32'(a_col), 32'(vec[c].col));
        chk("tab.pixel_active", c, 32'(a_act), 32'(vec[c].act));
        chk("tab.frame_start",  c, 32'(a_fs),  32'(vec[c].fs));
        chk("tab.line_start",   c, 32'(a_ls),  32'(vec[c].ls));
        chk("tab.hsync",        c, 32'(a_hs),  32'(vec[c].hs));
        chk("tab.vga_red",      c, 32'(a_vr),  32'(vec[c].vr));
        a_r = vec[c].r; a_g = vec[c].r; a_b = vec[c].r; a_fb = vec[c].fb;
      end else begin
        a_r = 4'($urandom); a_g = 4'($urandom); a_b = 4'($urandom);
        a_fb = ($urandom_range(0, 7) == 0);
      end
      ha[c] = '{r: a_r, g: a_g, b: a_b, fb: a_fb};

      // Drawer for B returns its own column, three cycles late, on red.
      bcol[c] = b_col;
      b_r = (c >= 3) ? bcol[c-3][3:0] : 4'($urandom);
      b_g = 4'($urandom); b_b = 4'($urandom);
      b_fb = ($urandom_range(0, 9) == 0);
      hb[c] = '{r: b_r, g: b_g, b: b_b, fb: b_fb};

      c_r = 4'($urandom); c_g = 4'($urandom); c_b = 4'($urandom);
      c_fb = ($urandom_range(0, 5) == 0);
      hc[c] = '{r: c_r, g: c_g, b: c_b, fb: c_fb};
    end
  endtask

  initial begin
    ca = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 0, 1, 16};
    cb = '{16, 2, 3, 3, 8, 1, 2, 2, 1, 1, 1, 3, 16};
    cc = '{8, 1, 2, 1, 4, 1, 1, 1, 0, 1, 2, 0, 3};
    z  = '{r: 4'd0, g: 4'd0, b: 4'd0, fb: 1'b0};

    // Default timing after release: pixel t's colour is driven at t+1 and
    // reaches the pins at t+2; force_blank at cycle 4 blanks cycle 5 only.
    vec[0] = '{r: 4'd5,  fb: 1'b0, col: 16'd0, act: 1'b1, fs: 1'b1, ls: 1'b1, hs: 1'b1, vr: 4'd0};
    vec[1] = '{r: 4'd6,  fb: 1'b0, col: 16'd1, act: 1'b1, fs: 1'b0, ls: 1'b0, hs: 1'b1, vr: 4'd0};
    vec[2] = '{r: 4'd7,  fb: 1'b0, col: 16'd2, act: 1'b1, fs: 1'b0, ls: 1'b0, hs: 1'b1, vr: 4'd6};
    vec[3] = '{r: 4'd8,  fb: 1'b0, col: 16'd3, act: 1'b1, fs: 1'b0, ls: 1'b0, hs: 1'b1, vr: 4'd7};
    vec[4] = '{r: 4'd9,  fb: 1'b1, col: 16'd4, act: 1'b1, fs: 1'b0, ls: 1'b0, hs: 1'b1, vr: 4'd8};
    vec[5] = '{r: 4'd10, fb: 1'b0, col: 16'd5, act: 1'b1, fs: 1'b0, ls: 1'b0, hs: 1'b1, vr: 4'd0};
    vec[6] = '{r: 4'd11, fb: 1'b0, col: 16'd6, act: 1'b1, fs: 1'b0, ls: 1'b0, hs: 1'b1, vr: 4'd10};

    rst_n = 1'b0;
    a_fb = 1'b0; a_r = '0; a_g = '0; a_b = '0;
    b_fb = 1'b0; b_r = '0; b_g = '0; b_b = '0;
    c_fb = 1'b0; c_r = '0; c_g = '0; c_b = '0;
    repeat (3) @(posedge clk);

    // Ends on a cycle where A's hsync pulse is in progress (h=700 delayed by 2).
    run(RUN1, 1'b1);
    chk("a.hsync_before_reset", RUN1 - 1, 32'(a_hs), 32'd0);

    // Asynchronous reset mid-line, well away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("_async_rst", 0, z, z, z);

    repeat (3) @(posedge clk);
    run(RUN2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
